// File: rtl/multiplier.sv
// Sequential shift-add multiply-accumulate: p = a*b + c over WIDTH iterations.
// Ports: clk, rst (async, active-high), start, a/b/c operands; busy, val, ovf, p.
module multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic               busy,
    output logic               val,
    output logic               ovf,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   p_q, p_d;
    logic            ovf_q, ovf_d;
    logic [PW-1:0]   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
        end
    end

    // The multiplicand walks left and the multiplier walks right, so each
    // iteration only inspects b_q[0] and adds the pre-shifted a_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        sum     = acc_q + (b_q[0] ? a_q : '0);

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = {{WIDTH{1'b0}}, a};
                    b_d     = b;
                    acc_d   = {{WIDTH{1'b0}}, c};
                end
            end
            RUN: begin
                acc_d = sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Result lands on p only here, so p never shows
                    // partial sums.
                    state_d = DONE;
                    p_d     = sum;
                    ovf_d   = |sum[PW-1:WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign val  = (state_q == DONE);
    assign ovf  = ovf_q;
    assign p    = p_q;

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be >= 2.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled on rising clk.
REQ-005 busy  output  1  high while an operation is in progress.
REQ-006 val  output  1  high while p and ovf hold a completed result.
REQ-007 ovf  output  1  completed result does not fit in WIDTH bits.
REQ-008 a  input  WIDTH  multiplicand (unsigned).
REQ-009 b  input  WIDTH  multiplier (unsigned).
REQ-010 c  input  WIDTH  addend (unsigned); the block computes p = a*b + c, the inverse of divider (x = q*y + r).
REQ-011 p  output  2*WIDTH  result, unsigned.

Function
REQ-012 States: IDLE, RUN, DONE; internal iteration counter of ceil(log2(WIDTH+1)) bits.
REQ-013 Accept rule: start=1 at a rising edge while state is IDLE or DONE SHALL latch a, b, c, clear val, set busy, load counter with 0, enter RUN.
REQ-014 start while RUN SHALL be ignored; the operation in progress and its latched operands SHALL be unaffected by changes on a, b, c.
REQ-015 Algorithm: shift-add; accumulator initialised to zero-extended c; on iteration i (0..WIDTH-1), if bit i of latched b is 1, add latched a shifted left by i, computed in 2*WIDTH bits; no intermediate truncation.
REQ-016 Latency: start accepted at edge N; busy=1 after edges N..N+WIDTH-1; at edge N+WIDTH: busy=0, val=1, p and ovf valid, state DONE.
REQ-017 ovf SHALL equal 1 iff p[2*WIDTH-1:WIDTH] is nonzero; updated only together with val rising.
REQ-018 In DONE, p, ovf, val SHALL hold until the next accepted start or reset.
REQ-019 start at the same edge val goes high is not possible (state is RUN); start in DONE is accepted per REQ-013 and val falls at that edge.
REQ-020 busy and val SHALL never be high simultaneously.
REQ-021 p SHALL not change while busy=0 except at reset; intermediate accumulator values need not appear on p.
REQ-022 Max arithmetic: (2^WIDTH-1)^2 + (2^WIDTH-1) = 2^(2*WIDTH) - 2^WIDTH SHALL fit p without wrap.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, busy=0, val=0, ovf=0, p=0, counter=0, independent of clk.
REQ-024 rst asserted mid-RUN SHALL abandon the operation; no val pulse after release.
REQ-025 First edge after rst deasserts with start=1 SHALL accept per REQ-013.

Verification
REQ-026 rst, then start=1 a=3 b=3 c=2 for one edge, start=0 -> busy high 8 cycles, then val=1, p=11, ovf=0.
REQ-027 a=0 b=200 c=7 -> after 8 cycles p=7, ovf=0; then a=0 b=254 c=248 -> p=248, ovf=0.
REQ-028 a=255 b=255 c=255 -> p=65280, ovf=1, val=1.
REQ-029 start a=10 b=10 c=0, then during RUN pulse start with a=1 b=1 c=1 -> ignored; final p=100; val then held 5 cycles with p=100 unchanged.
REQ-030 start a=15 b=15 c=0, assert rst after 3 cycles for one cycle -> busy=0, val=0, p=0 immediately; no val afterward until a new start.
REQ-031 From DONE (p=100) apply start a=2 b=5 c=1 -> val falls at that edge, busy high 8 cycles, then p=11, val=1.
